// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared game types, HID keycodes and playfield geometry defaults.
// Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        RESTART = 2'd0,
        PLAY    = 2'd1,
        WIN     = 2'd2,
        DEAD    = 2'd3
    } game_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_R = 8'h15;

    localparam logic [9:0] DEF_GOAL_X0 = 10'd440;
    localparam logic [9:0] DEF_GOAL_X1 = 10'd460;
    localparam logic [9:0] DEF_GOAL_Y0 = 10'd254;
    localparam logic [9:0] DEF_GOAL_Y1 = 10'd274;
    localparam logic [9:0] DEF_FALL_Y  = 10'd340;

    // Inclusive rectangle test on a sprite's top-left corner.
    function automatic logic in_rect(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] x0,
        input logic [9:0] x1,
        input logic [9:0] y0,
        input logic [9:0] y1
    );
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module  : frame_tick_sync
// Purpose : Brings frame_clk into the clk domain and emits a one-cycle tick
//           per rising edge.
// Rev     : 1.0  initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= frame_clk;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign tick = sync & ~sync_d;

endmodule
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_state_ctrl
// Purpose : Round outcome FSM (restart/play/win/dead) with HUD round timer.
//           Optional lives/respawn support under GAME_STATE_LIVES_EN.
// Rev     : 1.0  initial release
// ============================================================================
module game_state_ctrl
    import game_pkg::*;
#(
    parameter logic [9:0] GOAL_X0        = DEF_GOAL_X0,
    parameter logic [9:0] GOAL_X1        = DEF_GOAL_X1,
    parameter logic [9:0] GOAL_Y0        = DEF_GOAL_Y0,
    parameter logic [9:0] GOAL_Y1        = DEF_GOAL_Y1,
    parameter logic [9:0] FALL_Y         = DEF_FALL_Y,
    parameter logic [1:0] HAZ_FRAMES     = 2'd3,
    parameter logic [5:0] FRAMES_PER_SEC = 6'd60,
    parameter logic [1:0] LIVES_INIT     = 2'd3
) (
    input  logic        clk_125MHz,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  ManX,
    input  logic [9:0]  ManY,
    input  logic [15:0] keycode,
    output logic        Win,
    output logic        Dead,
    output logic        Man_Reset,
    output logic [9:0]  Time_Sec,
    output logic [1:0]  Lives
);

    logic tick;

    frame_tick_sync u_tick (
        .clk       (clk_125MHz),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    game_state_t state;
    game_state_t state_nxt;
    logic        rst_cnt;
    logic        rst_cnt_nxt;
    logic [1:0]  haz_cnt;
    logic [1:0]  haz_nxt;
    logic [1:0]  haz_inc;
    logic [5:0]  div_cnt;
    logic [5:0]  div_nxt;
    logic [9:0]  sec_cnt;
    logic [9:0]  sec_nxt;
    logic        rearm;
    logic        rearm_nxt;
    logic        clr_timer;
    logic        hazard;
    logic        goal;
    logic        key_r;
    logic        death;
    logic        restart;

    assign hazard  = (ManY >= FALL_Y);
    assign goal    = in_rect(ManX, ManY, GOAL_X0, GOAL_X1, GOAL_Y0, GOAL_Y1);
    assign key_r   = (keycode[7:0] == KEY_R) || (keycode[15:8] == KEY_R);
    assign haz_inc = (haz_cnt == 2'd3) ? 2'd3 : haz_cnt + 2'd1;
    assign death   = hazard && (haz_inc >= HAZ_FRAMES);
    assign restart = key_r && rearm;

`ifdef GAME_STATE_LIVES_EN
    logic [1:0] lives;
    logic [1:0] lives_nxt;
    assign Lives = lives;
`else
    assign Lives = LIVES_INIT;
`endif

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        haz_nxt     = haz_cnt;
        div_nxt     = div_cnt;
        sec_nxt     = sec_cnt;
        rearm_nxt   = rearm;
        clr_timer   = 1'b0;
`ifdef GAME_STATE_LIVES_EN
        lives_nxt   = lives;
`endif
        if (tick) begin
            if ((state != RESTART) && !key_r) begin
                rearm_nxt = 1'b1;
            end
            case (state)
                RESTART: begin
                    // Second tick after entry ends the restart window.
                    if (rst_cnt) begin
                        state_nxt   = PLAY;
                        rst_cnt_nxt = 1'b0;
                    end else begin
                        rst_cnt_nxt = 1'b1;
                    end
                end
                PLAY: begin
                    haz_nxt = hazard ? haz_inc : 2'd0;
                    if (div_cnt == FRAMES_PER_SEC - 6'd1) begin
                        div_nxt = 6'd0;
                        if (sec_cnt != 10'd999) begin
                            sec_nxt = sec_cnt + 10'd1;
                        end
                    end else begin
                        div_nxt = div_cnt + 6'd1;
                    end
                    if (goal) begin
                        state_nxt = WIN;
                    end else if (death) begin
`ifdef GAME_STATE_LIVES_EN
                        if (lives > 2'd1) begin
                            lives_nxt = lives - 2'd1;
                            state_nxt = RESTART;
                        end else begin
                            lives_nxt = 2'd0;
                            state_nxt = DEAD;
                        end
`else
                        state_nxt = DEAD;
`endif
                    end else if (restart) begin
                        state_nxt = RESTART;
                        clr_timer = 1'b1;
                    end
                end
                WIN, DEAD: begin
                    if (restart) begin
                        state_nxt = RESTART;
                        clr_timer = 1'b1;
`ifdef GAME_STATE_LIVES_EN
                        lives_nxt = LIVES_INIT;
`endif
                    end
                end
                default: begin
                    state_nxt = RESTART;
                end
            endcase
        end
        if (clr_timer) begin
            div_nxt = 6'd0;
            sec_nxt = 10'd0;
        end
        if (state == RESTART) begin
            haz_nxt   = 2'd0;
            rearm_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_125MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= RESTART;
            rst_cnt   <= 1'b0;
            haz_cnt   <= 2'd0;
            div_cnt   <= 6'd0;
            sec_cnt   <= 10'd0;
            rearm     <= 1'b0;
            Win       <= 1'b0;
            Dead      <= 1'b0;
            Man_Reset <= 1'b1;
`ifdef GAME_STATE_LIVES_EN
            lives     <= LIVES_INIT;
`endif
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            haz_cnt   <= haz_nxt;
            div_cnt   <= div_nxt;
            sec_cnt   <= sec_nxt;
            rearm     <= rearm_nxt;
            Win       <= (state_nxt == WIN);
            Dead      <= (state_nxt == DEAD);
            Man_Reset <= (state_nxt == RESTART);
`ifdef GAME_STATE_LIVES_EN
            lives     <= lives_nxt;
`endif
        end
    end

    assign Time_Sec = sec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_state_ctrl
// Purpose : Self-checking bench for game_state_ctrl (per-frame outcome model).
// Rev     : 1.0  initial release
// ============================================================================
module tb_game_state_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  man_x     = 10'd0;
    logic [9:0]  man_y     = 10'd0;
    logic [15:0] keycode   = 16'd0;
    logic        win, dead, man_reset;
    logic [9:0]  time_sec;
    logic [1:0]  lives;
    logic        win2, dead2, man_reset2;
    logic [9:0]  time_sec2;
    logic [1:0]  lives2;

    always #4 clk = ~clk;

    game_state_ctrl u_dut (
        .clk_125MHz (clk),
        .Reset_n    (rst_n),
        .frame_clk  (frame_clk),
        .ManX       (man_x),
        .ManY       (man_y),
        .keycode    (keycode),
        .Win        (win),
        .Dead       (dead),
        .Man_Reset  (man_reset),
        .Time_Sec   (time_sec),
        .Lives      (lives)
    );

    // Goal band overlapping the fall zone, so goal and death can coincide.
    game_state_ctrl #(
        .GOAL_Y0 (10'd330),
        .GOAL_Y1 (10'd360)
    ) u_dut2 (
        .clk_125MHz (clk),
        .Reset_n    (rst_n),
        .frame_clk  (frame_clk),
        .ManX       (man_x),
        .ManY       (man_y),
        .keycode    (keycode),
        .Win        (win2),
        .Dead       (dead2),
        .Man_Reset  (man_reset2),
        .Time_Sec   (time_sec2),
        .Lives      (lives2)
    );

    localparam int M_RESTART = 0;
    localparam int M_PLAY    = 1;
    localparam int M_WIN     = 2;
    localparam int M_DEAD    = 3;

    int m_mode, m_rticks, m_frames, m_run, m_lives;
    bit m_armed;

    function automatic int m_time();
        int s;
        s = m_frames / 60;
        return (s > 999) ? 999 : s;
    endfunction

    task automatic model_reset();
        m_mode = M_RESTART; m_rticks = 0; m_frames = 0; m_run = 0;
        m_lives = 3; m_armed = 1'b0;
    endtask

    task automatic enter_restart(input bit clear);
        m_mode = M_RESTART; m_rticks = 0; m_run = 0; m_armed = 1'b0;
        if (clear) m_frames = 0;
    endtask

    task automatic model_tick(input logic [9:0] x, input logic [9:0] y, input logic [15:0] k);
        bit kr, goal, haz, armed_before;
        kr   = (k[7:0] == 8'h15) || (k[15:8] == 8'h15);
        goal = (x >= 440) && (x <= 460) && (y >= 254) && (y <= 274);
        haz  = (y >= 340);
        if (m_mode == M_RESTART) begin
            m_rticks++;
            if (m_rticks == 2) begin
                m_mode = M_PLAY; m_rticks = 0;
            end
            return;
        end
        armed_before = m_armed;
        if (!kr) m_armed = 1'b1;
        if (m_mode == M_PLAY) begin
            m_frames++;
            m_run = haz ? m_run + 1 : 0;
            if (goal) m_mode = M_WIN;
            else if (m_run >= 3) begin
`ifdef GAME_STATE_LIVES_EN
                if (m_lives > 1) begin
                    m_lives--; enter_restart(1'b0);
                end else begin
                    m_lives = 0; m_mode = M_DEAD;
                end
`else
                m_mode = M_DEAD;
`endif
            end else if (kr && armed_before) enter_restart(1'b1);
        end else if (kr && armed_before) begin
`ifdef GAME_STATE_LIVES_EN
            m_lives = 3;
`endif
            enter_restart(1'b1);
        end
    endtask

    int    n_checks = 0;
    int    n_pass   = 0;
    int    p_seq    = 0;
    int    p_sig    = 0;
    int    p_lit    = 0;
    string p_name   = "";
    bit    chk_en   = 1'b0;

    function automatic int dut_val(input int s);
        case (s)
            0: return int'(win);
            1: return int'(dead);
            2: return int'(man_reset);
            3: return int'(time_sec);
            4: return int'(lives);
            5: return int'(win2);
            default: return int'(dead2);
        endcase
    endfunction

    function automatic int mod_val(input int s);
        case (s)
            0: return int'(m_mode == M_WIN);
            1: return int'(m_mode == M_DEAD);
            2: return int'(m_mode == M_RESTART);
            3: return m_time();
            4: return m_lives;
            default: return -1;
        endcase
    endfunction

    // Single compare process: every-cycle model check plus queued literal pins.
    initial begin : compare
        int p_done;
        logic ew, ed, er;
        p_done = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ew = (m_mode == M_WIN);
                ed = (m_mode == M_DEAD);
                er = (m_mode == M_RESTART);
                n_checks++;
                if (win === ew && dead === ed && man_reset === er &&
                    time_sec === 10'(m_time()) && lives === 2'(m_lives))
                    n_pass++;
                else
                    $display("FAIL cycle t=%0t win/dead/mreset/time/lives got %b %b %b %0d %0d want %b %b %b %0d %0d",
                             $time, win, dead, man_reset, time_sec, lives, ew, ed, er, m_time(), m_lives);
            end
            if (p_seq != p_done) begin
                p_done = p_seq;
                n_checks++;
                if (dut_val(p_sig) == p_lit) n_pass++;
                else $display("FAIL %s got %0d want %0d", p_name, dut_val(p_sig), p_lit);
                if (mod_val(p_sig) >= 0) begin
                    n_checks++;
                    if (mod_val(p_sig) == p_lit) n_pass++;
                    else $display("FAIL %s_model got %0d want %0d", p_name, mod_val(p_sig), p_lit);
                end
            end
        end
    end

    task automatic pin(input string name, input int sig, input int lit);
        p_name = name; p_sig = sig; p_lit = lit; p_seq++;
        @(negedge clk); #1;
    endtask

    task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [15:0] k);
        @(negedge clk);
        man_x = x; man_y = y; keycode = k; frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        model_tick(x, y, k);
        repeat (5) @(negedge clk);
        frame_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K_RLO  = 16'h0015;
    localparam logic [15:0] K_RHI  = 16'h1500;

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        pin("rst_man_reset", 2, 1);
        pin("rst_win", 0, 0);
        pin("rst_dead", 1, 0);
        pin("rst_time", 3, 0);
        pin("rst_lives", 4, 3);

        frame(10'd100, 10'd100, K_NONE);
        pin("restart_tick1", 2, 1);
        frame(10'd100, 10'd100, K_NONE);
        pin("play_entry", 2, 0);

        repeat (130) frame(10'd100, 10'd100, K_NONE);
        pin("time_130_ticks", 3, 2);
        frame(10'd450, 10'd260, K_NONE);
        pin("goal_win", 0, 1);
        repeat (120) frame(10'd100, 10'd100, K_NONE);
        pin("win_time_frozen", 3, 2);
        pin("win_held", 0, 1);

        frame(10'd100, 10'd100, K_RLO);
        pin("win_restart", 2, 1);
        pin("restart_time_clr", 3, 0);
        frame(10'd100, 10'd100, K_RLO);
        pin("r_held_restart", 2, 1);
        frame(10'd100, 10'd100, K_RLO);
        pin("r_held_play", 2, 0);
        repeat (3) frame(10'd100, 10'd100, K_RLO);
        pin("r_held_no_retrigger", 2, 0);

        frame(10'd100, 10'd345, K_NONE);
        frame(10'd100, 10'd345, K_NONE);
        frame(10'd100, 10'd300, K_NONE);
        frame(10'd100, 10'd345, K_NONE);
        frame(10'd100, 10'd345, K_NONE);
        pin("hazard_two_alive", 1, 0);
        frame(10'd100, 10'd345, K_NONE);
`ifdef GAME_STATE_LIVES_EN
        pin("respawn_lives", 4, 2);
        pin("respawn_man_reset", 2, 1);
`else
        pin("hazard_three_dead", 1, 1);
`endif
        frame(10'd100, 10'd100, K_RHI);
`ifndef GAME_STATE_LIVES_EN
        pin("dead_restart_hi", 2, 1);
        pin("dead_restart_time", 3, 0);
`endif
        frame(10'd100, 10'd100, K_RHI);
        frame(10'd100, 10'd100, K_RHI);
        frame(10'd100, 10'd100, K_RHI);
        pin("r_hi_held_play", 2, 0);

`ifdef GAME_STATE_LIVES_EN
        frame(10'd100, 10'd100, K_NONE);
        repeat (3) frame(10'd100, 10'd345, K_NONE);
        pin("second_death_lives", 4, 1);
        repeat (2) frame(10'd100, 10'd100, K_NONE);
        repeat (3) frame(10'd100, 10'd345, K_NONE);
        pin("last_death_dead", 1, 1);
        pin("last_death_lives", 4, 0);
        frame(10'd100, 10'd100, K_RLO);
        pin("reload_lives", 4, 3);
`endif

        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pin("rerst_man_reset", 2, 1);
        frame(10'd100, 10'd100, K_NONE);
        frame(10'd100, 10'd100, K_NONE);
        frame(10'd100, 10'd345, K_NONE);
        frame(10'd100, 10'd345, K_NONE);
        frame(10'd450, 10'd345, K_NONE);
        pin("goal_beats_death_win", 5, 1);
        pin("goal_beats_death_dead", 6, 0);
`ifndef GAME_STATE_LIVES_EN
        pin("default_goal_rect_dead", 1, 1);
`endif

        chk_en = 1'b0;
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
